// File: rtl/wb_regfile_pkg.sv
// Shared register-file constants: bus widths, enables and the hardwired-zero address.
package wb_regfile_pkg;
    localparam int   REG_BUS_W     = 32;
    localparam int   REG_ADDR_W    = 5;
    localparam int   REG_NUM       = 32;
    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'b00000;
endpackage

// File: rtl/wb_regfile_wb_stage_reg.sv
// One-deep write-back capture register; flush clears the entry, stall holds it.
module wb_stage_reg
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o
);
    logic [ADDR_W-1:0] r_wd;
    logic              r_wreg;
    logic [DATA_W-1:0] r_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_wd    <= '0;
            r_wreg  <= WRITE_DISABLE;
            r_wdata <= '0;
        end else if (flush_i) begin
            r_wd    <= '0;
            r_wreg  <= WRITE_DISABLE;
            r_wdata <= '0;
        end else if (!stall_i) begin
            r_wd    <= wd_i;
            r_wreg  <= wreg_i;
            r_wdata <= wdata_i;
        end
    end

    assign wb_wd_o    = r_wd;
    assign wb_wreg_o  = r_wreg;
    assign wb_wdata_o = r_wdata;
endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: pending entry commits one edge after capture,
// two read ports bypass from the pending entry, $0 reads as zero.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = REG_BUS_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              wb_valid_o
);
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [ADDR_W-1:0] w_wb_wd;
    logic              w_wb_wreg;
    logic [DATA_W-1:0] w_wb_wdata;
    logic              w_commit;

    wb_stage_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wb_stage_reg (
        .clk        (clk),
        .rst        (rst),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .wb_wd_o    (w_wb_wd),
        .wb_wreg_o  (w_wb_wreg),
        .wb_wdata_o (w_wb_wdata)
    );

    // A stalled entry must not commit, even when it is being flushed.
    assign w_commit = (w_wb_wreg == WRITE_ENABLE) && (w_wb_wd != NOP_REG_ADDR) && !stall_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[w_wb_wd] <= w_wb_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_in,
        input logic              re,
        input logic [ADDR_W-1:0] addr,
        input logic              wb_wreg,
        input logic [ADDR_W-1:0] wb_wd,
        input logic [DATA_W-1:0] wb_wdata,
        input logic [DATA_W-1:0] arr_data
    );
        logic [DATA_W-1:0] data;
        data = '0;
        if (rst_in == RST_ENABLE || re == READ_DISABLE || addr == NOP_REG_ADDR) begin
            data = '0;
        end else if (wb_wreg == WRITE_ENABLE && wb_wd == addr) begin
            data = wb_wdata;
        end else begin
            data = arr_data;
        end
        return data;
    endfunction

    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        rdata1_o = read_port(rst, re1_i, raddr1_i, w_wb_wreg, w_wb_wd, w_wb_wdata, r_regs[raddr1_i]);
        rdata2_o = read_port(rst, re2_i, raddr2_i, w_wb_wreg, w_wb_wd, w_wb_wdata, r_regs[raddr2_i]);
    end

    assign wb_valid_o = (rst == RST_ENABLE) ? 1'b0 : w_wb_wreg;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: bypass, commit timing, $0, stall/flush and reset.
module tb_wb_regfile;
    logic        clk;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        stall_i;
    logic        flush_i;
    logic        re1_i;
    logic [4:0]  raddr1_i;
    logic [31:0] rdata1_o;
    logic        re2_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata2_o;
    logic        wb_valid_o;

    int vec_cnt;
    int err_cnt;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .re1_i      (re1_i),
        .raddr1_i   (raddr1_i),
        .rdata1_o   (rdata1_o),
        .re2_i      (re2_i),
        .raddr2_i   (raddr2_i),
        .rdata2_o   (rdata2_o),
        .wb_valid_o (wb_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs then change 1 time unit after it, outputs settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] a, input logic we, input logic [31:0] d);
        wd_i    = a;
        wreg_i  = we;
        wdata_i = d;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        raddr1_i = a1;
        raddr2_i = a2;
        #1;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        present(5'd0, 1'b0, 32'h0);
        stall_i = 1'b0; flush_i = 1'b0;
        re1_i = 1'b1; re2_i = 1'b1;
        raddr1_i = 5'd5; raddr2_i = 5'd5;
        #12;
        check("rst_rd1", rdata1_o, 32'h0);
        check("rst_rd2", rdata2_o, 32'h0);
        check("rst_valid", {31'b0, wb_valid_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Reset discards committed and pending state
        present(5'd5, 1'b1, 32'h1234);
        step();
        present(5'd0, 1'b0, 32'h0);
        rd(5'd5, 5'd5);
        check("r5_bypass", rdata1_o, 32'h1234);
        step();
        rd(5'd5, 5'd5);
        check("r5_array", rdata1_o, 32'h1234);
        present(5'd5, 1'b1, 32'h5678);
        step();
        #2 rst = 1'b1;
        #1;
        check("r5_rst_async", rdata1_o, 32'h0);
        #1 rst = 1'b0;
        present(5'd0, 1'b0, 32'h0);
        #1;
        check("r5_after_rst", rdata1_o, 32'h0);
        check("valid_after_rst", {31'b0, wb_valid_o}, 32'h0);

        // Basic write, bypass, commit
        step();
        present(5'd3, 1'b1, 32'hDEADBEEF);
        step();
        present(5'd0, 1'b0, 32'h0);
        rd(5'd3, 5'd3);
        check("r3_bypass", rdata1_o, 32'hDEADBEEF);
        check("r3_valid", {31'b0, wb_valid_o}, 32'h1);
        step();
        rd(5'd3, 5'd3);
        check("r3_array", rdata1_o, 32'hDEADBEEF);
        check("r3_array_p2", rdata2_o, 32'hDEADBEEF);
        check("r3_valid_clr", {31'b0, wb_valid_o}, 32'h0);

        // Read enables
        re1_i = 1'b0;
        rd(5'd3, 5'd3);
        check("re1_off", rdata1_o, 32'h0);
        check("re2_on", rdata2_o, 32'hDEADBEEF);
        re1_i = 1'b1;

        // $0 is never written or bypassed
        present(5'd0, 1'b1, 32'hFFFFFFFF);
        step();
        present(5'd0, 1'b0, 32'h0);
        rd(5'd0, 5'd0);
        check("r0_valid", {31'b0, wb_valid_o}, 32'h1);
        check("r0_bypass_p1", rdata1_o, 32'h0);
        check("r0_bypass_p2", rdata2_o, 32'h0);
        step();
        rd(5'd0, 5'd0);
        check("r0_array_p1", rdata1_o, 32'h0);
        check("r0_array_p2", rdata2_o, 32'h0);

        // Non-valid capture
        present(5'd12, 1'b0, 32'h99);
        step();
        present(5'd0, 1'b0, 32'h0);
        rd(5'd12, 5'd12);
        check("r12_nobypass", rdata1_o, 32'h0);
        step();
        rd(5'd12, 5'd12);
        check("r12_nocommit", rdata1_o, 32'h0);

        // Back-to-back writes to the same register
        present(5'd7, 1'b1, 32'h11);
        step();
        rd(5'd7, 5'd7);
        check("r7_first", rdata1_o, 32'h11);
        present(5'd7, 1'b1, 32'h22);
        step();
        present(5'd0, 1'b0, 32'h0);
        rd(5'd7, 5'd7);
        check("r7_newer_p1", rdata1_o, 32'h22);
        check("r7_newer_p2", rdata2_o, 32'h22);
        step();
        step();
        rd(5'd7, 5'd7);
        check("r7_array", rdata1_o, 32'h22);

        // Stall holds the entry, release commits it
        present(5'd9, 1'b1, 32'hAA);
        step();
        present(5'd0, 1'b0, 32'h0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd(5'd9, 5'd9);
            check("r9_stall_bypass", rdata1_o, 32'hAA);
            check("r9_stall_valid", {31'b0, wb_valid_o}, 32'h1);
            step();
        end
        stall_i = 1'b0;
        step();
        rd(5'd9, 5'd9);
        check("r9_commit", rdata1_o, 32'hAA);
        check("r9_valid_clr", {31'b0, wb_valid_o}, 32'h0);

        // Flush without stall still commits the old entry
        present(5'd10, 1'b1, 32'h55);
        step();
        present(5'd0, 1'b0, 32'h0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        rd(5'd10, 5'd10);
        check("r10_flush_valid", {31'b0, wb_valid_o}, 32'h0);
        check("r10_flush_commit", rdata1_o, 32'h55);

        // Flush with stall loses the entry; stalled cycles never committed it
        pulse_reset();
        present(5'd10, 1'b1, 32'h77);
        step();
        present(5'd0, 1'b0, 32'h0);
        stall_i = 1'b1;
        step();
        rd(5'd10, 5'd10);
        check("r10_stall_bypass", rdata2_o, 32'h77);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        stall_i = 1'b0;
        rd(5'd10, 5'd10);
        check("r10_fs_valid", {31'b0, wb_valid_o}, 32'h0);
        check("r10_fs_p1", rdata1_o, 32'h0);
        check("r10_fs_p2", rdata2_o, 32'h0);
        step();
        rd(5'd10, 5'd10);
        check("r10_fs_later", rdata1_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the execute-stage result interface (destination address, write enable, write data).
- Captures the execute result in a one-deep write-back register, then commits it to a 32x32 general register file on the following edge.
- Serves two combinational read ports to decode, with bypass from the pending write-back entry.
- Register $0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width; matches RegBus.
- ADDR_W, 5, register address width; matches RegAddrBus.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset (RstEnable = 1'b1).
- wd_i  in  ADDR_W  destination register address from execute.
- wreg_i  in  1  write enable from execute.
- wdata_i  in  DATA_W  result data from execute.
- stall_i  in  1  hold the write-back register (no capture, no commit).
- flush_i  in  1  cancel the pending write-back entry.
- re1_i  in  1  read port 1 enable.
- raddr1_i  in  ADDR_W  read port 1 address.
- rdata1_o  out  DATA_W  read port 1 data (combinational).
- re2_i  in  1  read port 2 enable.
- raddr2_i  in  ADDR_W  read port 2 address.
- rdata2_o  out  DATA_W  read port 2 data (combinational).
- wb_valid_o  out  1  write-back register holds a pending write (wb_wreg).

Behaviour:
Reset:
- rst asserted asynchronously clears all NUM_REGS array entries, wb_wd, wb_wreg and wb_wdata to 0.
- While rst is high, rdata1_o, rdata2_o and wb_valid_o are 0.
- Reset mid-operation discards any pending write.

Each rising edge with rst low:
- Commit: if wb_wreg=1, wb_wd!=0 and stall_i=0, then regs[wb_wd] <= wb_wdata.
- Capture, priority flush_i > stall_i:
  - flush_i=1: wb_wreg <= 0; wb_wd and wb_wdata <= 0. Commit of the old entry still occurs if stall_i=0.
  - stall_i=1 (no flush): wb register holds, no commit; the entry persists and stays visible to bypass.
  - otherwise: wb_wd <= wd_i, wb_wreg <= wreg_i, wb_wdata <= wdata_i.

Latency:
- Execute result visible on read ports one cycle after presentation, via bypass.
- Result committed to the array two edges after presentation, absent stall.

Read port n (identical logic per port), priority order:
1. re_n=0 -> 0.
2. raddr_n=0 -> 0.
3. wb_wreg=1 and wb_wd=raddr_n -> wb_wdata (bypass).
4. otherwise regs[raddr_n].

Boundary rules:
- Write to $0 is captured (wb_valid_o=1) but never commits; bypass to $0 is suppressed.
- Back-to-back writes to the same address: the newer value wins on both bypass and array.
- Both read ports may hit the same address or the bypass simultaneously; each returns the same value.
- wreg_i=0 captures a non-valid entry; no commit, no bypass.
- stall_i and flush_i asserted together: flush wins, and no commit occurs because stall_i=1. The pending write is lost; this is the caller's responsibility.

Decomposition:
- Shared defines package (existing defines.v) provides:
  - RstEnable, ZeroWord, RegBus, RegAddrBus
  - WriteEnable/WriteDisable, ReadEnable/ReadDisable
  - RegNum (32) and NOPRegAddr (5'b00000)
- Natural sub-module: wb_stage_reg (write-back capture register with stall/flush).
- The array and read-port bypass remain in wb_regfile.

Test Plan:
- Reset: write 0x1234 to r5, assert rst mid-cycle -> rdata immediately 0; after release, reading r5 returns 0 and wb_valid_o=0.
- Basic write/bypass/commit:
  - Present wd=3, wreg=1, wdata=0xDEADBEEF.
  - Next cycle read r3 -> 0xDEADBEEF via bypass.
  - After the second edge, with wreg_i=0, read r3 -> 0xDEADBEEF from the array.
- $0 protection: write 0xFFFFFFFF to r0 -> wb_valid_o=1, both ports reading r0 return 0 on every cycle.
- Back-to-back same address:
  - Write r7=0x11, then r7=0x22 on consecutive cycles.
  - Cycle after the second write: port 1 reads 0x22.
  - Two cycles later the array holds 0x22.
- Stall/flush:
  - Capture r9=0xAA, assert stall_i 3 cycles -> bypass reads 0xAA, array r9 unchanged (0).
  - Deassert stall -> commit, r9=0xAA.
  - Separately, capture r10=0x55 then flush_i with stall_i=0 -> r10 commits 0x55 and wb_valid_o=0.
  - Flush together with stall -> r10 stays 0.
- Read enables: re1_i=0, re2_i=1, both addressing r3=0xDEADBEEF -> rdata1_o=0, rdata2_o=0xDEADBEEF.
